regfile_sequencer: RTL and testbench

//  Initiator side of the 16-bit register-file port. Accepts one register op request
//  (rs1, rs2, rd, wb), drives the read addresses and captures the clocked read data.

---
 rtl/regfile_sequencer_if.sv | 50 +++++
 rtl/regfile_sequencer.sv | 121 ++++++++++++
 tb/tb_regfile_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sequencer_if.sv
// ----------------------------------------------------------------------------
// regfile_sequencer_if : request, register-file and execute-stage signals of the
//                        register-file sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface regfile_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
);
  logic              reqValid;
  logic              reqReady;
  logic [ADDR_W-1:0] reqRs1;
  logic [ADDR_W-1:0] reqRs2;
  logic [ADDR_W-1:0] reqRd;
  logic              reqWb;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeFile;
  logic              regWrite;
  logic              opValid;
  logic              opReady;
  logic [DATA_W-1:0] operandA;
  logic [DATA_W-1:0] operandB;
  logic              resValid;
  logic [DATA_W-1:0] result;
  logic              addrErr;
  logic [CNT_W-1:0]  txnCount;

  modport master (
    input  reqValid, reqRs1, reqRs2, reqRd, reqWb,
    input  readData1, readData2, opReady, resValid, result,
    output reqReady, readReg1, readReg2, writeReg, writeFile, regWrite,
    output opValid, operandA, operandB, addrErr, txnCount
  );

  modport slave (
    output reqValid, reqRs1, reqRs2, reqRd, reqWb,
    output readData1, readData2, opReady, resValid, result,
    input  reqReady, readReg1, readReg2, writeReg, writeFile, regWrite,
    input  opValid, operandA, operandB, addrErr, txnCount
  );
endinterface

`default_nettype wire

// File: rtl/regfile_sequencer.sv
// ----------------------------------------------------------------------------
// regfile_sequencer : initiator side of the register-file port; reads two
//                     operands, hands them to execute, writes the result back.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regfile_sequencer #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 6,
  parameter int CNT_W    = 8
) (
  input  wire logic           clock,
  input  wire logic           reset_n,
  regfile_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_EXEC    = 3'd3,
    S_WAIT    = 3'd4,
    S_WRITE   = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

  state_t            state;
  logic [ADDR_W-1:0] lat_rd;
  logic              lat_wb;
  logic              addr_bad;

  // Extra top bit keeps the compare correct even when NUM_REGS == 2**ADDR_W.
  assign addr_bad = ({1'b0, bus.reqRs1} >= REG_LIMIT) ||
                    ({1'b0, bus.reqRs2} >= REG_LIMIT) ||
                    ({1'b0, bus.reqRd}  >= REG_LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      lat_rd        <= '0;
      lat_wb        <= 1'b0;
      bus.reqReady  <= 1'b1;
      bus.readReg1  <= '0;
      bus.readReg2  <= '0;
      bus.writeReg  <= '0;
      bus.writeFile <= '0;
      bus.regWrite  <= 1'b0;
      bus.opValid   <= 1'b0;
      bus.operandA  <= '0;
      bus.operandB  <= '0;
      bus.addrErr   <= 1'b0;
      bus.txnCount  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.reqValid) begin
            lat_rd <= bus.reqRd;
            lat_wb <= bus.reqWb;
            if (addr_bad) begin
              // Bad request is counted but never touches the register file.
              bus.addrErr  <= 1'b1;
              bus.txnCount <= bus.txnCount + CNT_W'(1);
            end else begin
              bus.readReg1 <= bus.reqRs1;
              bus.readReg2 <= bus.reqRs2;
              bus.reqReady <= 1'b0;
              state        <= S_READ;
            end
          end
        end
        S_READ: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          bus.operandA <= bus.readData1;
          bus.operandB <= bus.readData2;
          bus.opValid  <= 1'b1;
          state        <= S_EXEC;
        end
        S_EXEC: begin
          if (bus.opReady) begin
            bus.opValid <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.resValid) begin
            bus.writeFile <= bus.result;
            if (lat_wb) begin
              bus.regWrite <= 1'b1;
              bus.writeReg <= lat_rd;
              state        <= S_WRITE;
            end else begin
              bus.reqReady <= 1'b1;
              bus.txnCount <= bus.txnCount + CNT_W'(1);
              state        <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          bus.regWrite <= 1'b0;
          bus.reqReady <= 1'b1;
          bus.txnCount <= bus.txnCount + CNT_W'(1);
          state        <= S_IDLE;
        end
        default: begin
          bus.regWrite <= 1'b0;
          bus.opValid  <= 1'b0;
          bus.reqReady <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
// ----------------------------------------------------------------------------
// tb_regfile_sequencer : directed requests against a register-file and adder
//                        execute model; expected operands/writes go to queues.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_regfile_sequencer;

  typedef struct { logic [15:0] a; logic [15:0] b; } op_t;
  typedef struct { logic [2:0] rd; logic [15:0] d; } wr_t;

  logic clock;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   accept_cyc, wr_cyc, res_cyc, idle_cyc;
  int   op_delay  = 0;
  int   res_delay = 0;
  int   exec_phase = 0;
  int   wr_seen   = 0;
  op_t  op_q[$];
  wr_t  wr_q[$];
  logic [15:0] regs [8];

  regfile_sequencer_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) bus ();

  regfile_sequencer #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(6), .CNT_W(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Register file: clocked read, write on regWrite, read sees the pre-write value.
  initial begin
    logic [2:0]  a1, a2, wa;
    logic [15:0] wd;
    logic        we;
    regs = '{16'h0000, 16'h0005, 16'h0003, 16'h0000, 16'h0100, 16'h0020, 16'h0000, 16'h0000};
    bus.readData1 = '0;
    bus.readData2 = '0;
    forever begin
      @(posedge clock);
      a1 = bus.readReg1; a2 = bus.readReg2;
      we = bus.regWrite; wa = bus.writeReg; wd = bus.writeFile;
      #1;
      bus.readData1 = regs[a1];
      bus.readData2 = regs[a2];
      if (we) regs[wa] = wd;
    end
  end

  // Execute stage: adder with programmable accept and result delays.
  initial begin
    int          cnt;
    logic [15:0] sum;
    bus.opReady = 1'b0; bus.resValid = 1'b0; bus.result = '0;
    cnt = 0; sum = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        exec_phase = 0; bus.opReady = 1'b0; bus.resValid = 1'b0;
      end else begin
        case (exec_phase)
          0: if (bus.opValid) begin
               cnt = op_delay;
               if (cnt == 0) begin bus.opReady = 1'b1; exec_phase = 2; end
               else exec_phase = 1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin bus.opReady = 1'b1; exec_phase = 2; end
             end
          2: begin
               bus.opReady = 1'b0;
               sum = bus.operandA + bus.operandB;
               cnt = res_delay;
               if (cnt == 0) begin bus.resValid = 1'b1; bus.result = sum; exec_phase = 3; end
               else exec_phase = 4;
             end
          4: begin
               cnt--;
               if (cnt == 0) begin bus.resValid = 1'b1; bus.result = sum; exec_phase = 3; end
             end
          default: begin
               bus.resValid = 1'b0; res_cyc = cyc; exec_phase = 0;
             end
        endcase
      end
    end
  end

  // Monitor: pops expectations on operand handshakes and writebacks.
  initial begin
    bit          prev_stall, prev_wr;
    logic [15:0] pa, pb;
    op_t         eo;
    wr_t         ew;
    prev_stall = 0; prev_wr = 0; pa = '0; pb = '0;
    forever begin
      @(negedge clock); #1;
      if (!reset_n) begin
        prev_stall = 0; prev_wr = 0;
      end else begin
        if (prev_wr) chk("regwrite_one_cycle", {31'b0, bus.regWrite}, 32'd0);
        if (prev_stall) begin
          chk("opvalid_held", {31'b0, bus.opValid}, 32'd1);
          chk("operandA_stable", {16'b0, bus.operandA}, {16'b0, pa});
          chk("operandB_stable", {16'b0, bus.operandB}, {16'b0, pb});
        end
        if (bus.opValid && bus.opReady) begin
          if (op_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_op actual=%0h/%0h required=none", bus.operandA, bus.operandB);
          end else begin
            eo = op_q.pop_front();
            chk("operandA", {16'b0, bus.operandA}, {16'b0, eo.a});
            chk("operandB", {16'b0, bus.operandB}, {16'b0, eo.b});
          end
        end
        if (bus.regWrite) begin
          wr_seen++; wr_cyc = cyc;
          if (wr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write actual=R%0d<=%0h required=none", bus.writeReg, bus.writeFile);
          end else begin
            ew = wr_q.pop_front();
            chk("writeReg", {29'b0, bus.writeReg}, {29'b0, ew.rd});
            chk("writeFile", {16'b0, bus.writeFile}, {16'b0, ew.d});
          end
        end
        prev_stall = bus.opValid && !bus.opReady;
        prev_wr    = bus.regWrite;
        pa = bus.operandA; pb = bus.operandB;
      end
    end
  end

  task automatic push_op(input logic [15:0] a, input logic [15:0] b);
    op_t o; o.a = a; o.b = b; op_q.push_back(o);
  endtask

  task automatic push_wr(input logic [2:0] rd, input logic [15:0] d);
    wr_t w; w.rd = rd; w.d = d; wr_q.push_back(w);
  endtask

  task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd, input logic wb);
    logic rdy;
    int   t;
    t = 0;
    @(negedge clock);
    bus.reqRs1 = rs1; bus.reqRs2 = rs2; bus.reqRd = rd; bus.reqWb = wb; bus.reqValid = 1'b1;
    forever begin
      #1 rdy = bus.reqReady;
      @(posedge clock);
      if (rdy) break;
      t++;
      if (t > 200) begin
        checks++; failures++;
        $display("FAIL accept_timeout actual=no_accept required=accept");
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    accept_cyc = cyc;
    bus.reqValid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    forever begin
      @(negedge clock); #1;
      if (bus.reqReady) break;
      t++;
      if (t > 200) begin
        checks++; failures++;
        $display("FAIL idle_timeout actual=busy required=idle");
        break;
      end
    end
    idle_cyc = cyc;
  endtask

  task automatic pulse_reset();
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); @(negedge clock); reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, t;
    reset_n = 1'b0;
    bus.reqValid = 1'b0; bus.reqRs1 = '0; bus.reqRs2 = '0; bus.reqRd = '0; bus.reqWb = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_reqReady", {31'b0, bus.reqReady}, 32'd1);
    chk("rst_regWrite", {31'b0, bus.regWrite}, 32'd0);
    chk("rst_opValid",  {31'b0, bus.opValid},  32'd0);
    chk("rst_addrErr",  {31'b0, bus.addrErr},  32'd0);
    chk("rst_txnCount", {24'b0, bus.txnCount}, 32'd0);
    chk("rst_readReg1", {29'b0, bus.readReg1}, 32'd0);
    chk("rst_operandA", {16'b0, bus.operandA}, 32'd0);
    chk("rst_writeFile", {16'b0, bus.writeFile}, 32'd0);
    @(negedge clock); reset_n = 1'b1;

    // R1 + R2 -> R3, minimum latency
    push_op(16'h0005, 16'h0003); push_wr(3'd3, 16'h0008);
    issue(3'd1, 3'd2, 3'd3, 1'b1);
    wait_idle();
    chk("latency_accept_to_write", wr_cyc - accept_cyc, 32'd4);
    chk("txn1_count", {24'b0, bus.txnCount}, 32'd1);

    // Same request without writeback
    push_op(16'h0005, 16'h0003);
    w0 = wr_seen;
    issue(3'd1, 3'd2, 3'd3, 1'b0);
    wait_idle();
    chk("ready_cycle_after_res", idle_cyc, res_cyc);
    chk("nowb_no_write", wr_seen - w0, 32'd0);
    chk("txn2_count", {24'b0, bus.txnCount}, 32'd2);

    // Stalled accept and delayed result: R3(8) + R1(5) -> R5
    op_delay = 5; res_delay = 3;
    push_op(16'h0008, 16'h0005); push_wr(3'd5, 16'h000D);
    w0 = wr_seen;
    issue(3'd3, 3'd1, 3'd5, 1'b1);
    wait_idle();
    chk("stall_one_write", wr_seen - w0, 32'd1);
    chk("txn3_count", {24'b0, bus.txnCount}, 32'd3);
    op_delay = 0; res_delay = 0;

    // Out-of-range source register
    w0 = wr_seen;
    issue(3'd6, 3'd0, 3'd0, 1'b1);
    #1;
    chk("adderr_set", {31'b0, bus.addrErr}, 32'd1);
    chk("adderr_ready", {31'b0, bus.reqReady}, 32'd1);
    chk("adderr_no_read", {29'b0, bus.readReg1}, 32'd3);
    repeat (4) @(negedge clock);
    #1;
    chk("adderr_no_write", wr_seen - w0, 32'd0);
    chk("adderr_count", {24'b0, bus.txnCount}, 32'd4);

    // Reset while waiting for the result
    res_delay = 20;
    push_op(16'h0005, 16'h0003);
    issue(3'd1, 3'd2, 3'd0, 1'b1);
    t = 0;
    while (exec_phase != 4 && t < 100) begin @(negedge clock); #1; t++; end
    chk("reached_wait", exec_phase, 32'd4);
    reset_n = 1'b0;
    #1;
    chk("midrst_regWrite", {31'b0, bus.regWrite}, 32'd0);
    chk("midrst_reqReady", {31'b0, bus.reqReady}, 32'd1);
    chk("midrst_count",    {24'b0, bus.txnCount}, 32'd0);
    chk("midrst_addrErr",  {31'b0, bus.addrErr},  32'd0);
    @(negedge clock); @(negedge clock); reset_n = 1'b1;
    res_delay = 0;
    push_op(16'h0100, 16'h000D); push_wr(3'd2, 16'h010D);
    issue(3'd4, 3'd5, 3'd2, 1'b1);
    wait_idle();
    chk("post_rst_count", {24'b0, bus.txnCount}, 32'd1);

    // 256 back-to-back transactions wrap the counter
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      push_op(16'h0000, 16'h0005);
      issue(3'd0, 3'd1, 3'd0, 1'b0);
      wait_idle();
      if (i == 254) chk("count_255", {24'b0, bus.txnCount}, 32'd255);
    end
    chk("count_wrap", {24'b0, bus.txnCount}, 32'd0);

    // rs1 == rs2 == rd, then read back the written register
    push_op(16'h0100, 16'h0100); push_wr(3'd4, 16'h0200);
    issue(3'd4, 3'd4, 3'd4, 1'b1);
    wait_idle();
    push_op(16'h0200, 16'h0000);
    issue(3'd4, 3'd0, 3'd0, 1'b0);
    wait_idle();

    repeat (10) @(negedge clock);
    chk("op_queue_empty", op_q.size(), 32'd0);
    chk("wr_queue_empty", wr_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
